ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch_pkg.sv | 29 ++
 rtl/inst_counter.sv | 31 +++
 rtl/ifu_fetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module   : ifu_fetch_pkg
// Brief    : Shared fetch-unit configuration: widths, reset PC, FSM encodings.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

package ifu_fetch_pkg;

  localparam int          ISA_W           = `ISA_WIDTH;
  localparam logic [31:0] RESET_PC_DEF    = 32'h8000_0000;
  localparam int          INST_ALIGN_BITS = 2;
  localparam int          INST_CNT_W      = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_EXEC = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_counter.sv
// ============================================================================
// Module   : inst_counter
// Brief    : Free-running committed-instruction counter, wraps silently.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_counter
  import ifu_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [INST_CNT_W-1:0] count
);

  logic [INST_CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Brief    : Single-outstanding instruction fetch unit with PC, FSM and latch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                   ISA_WIDTH = `ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = ISA_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ISA_WIDTH-1:0]  pc_in,
  input  logic                  pc_w_en,
  output logic [ISA_WIDTH-1:0]  pc_out,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ISA_WIDTH-1:0]  imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [ISA_WIDTH-1:0]  imem_rsp_data,
  output logic [ISA_WIDTH-1:0]  inst,
  output logic                  inst_valid,
  output logic                  misalign,
  output logic [INST_CNT_W-1:0] inst_cnt
);

  fetch_state_t         r_state;
  logic [ISA_WIDTH-1:0] r_pc;
  logic [ISA_WIDTH-1:0] r_inst;
  logic                 r_req_valid;
  logic                 r_inst_valid;
  logic                 r_misalign;

  logic w_aligned;
  logic w_commit;

  assign w_aligned = (pc_in[INST_ALIGN_BITS-1:0] == '0);
  assign w_commit  = (r_state == ST_EXEC) && pc_w_en && w_aligned;

  // Valid flags are tracked as registers next to the state so no input
  // ever reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_REQ;
          r_req_valid <= 1'b1;
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            r_inst       <= imem_rsp_data;
            r_state      <= ST_EXEC;
            r_inst_valid <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (pc_w_en) begin
            r_inst_valid <= 1'b0;
            if (w_aligned) begin
              r_pc        <= pc_in;
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_misalign <= 1'b1;
              r_state    <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state      <= ST_HALT;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  inst_counter u_inst_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (w_commit),
    .count (inst_cnt)
  );

  assign pc_out         = r_pc;
  assign imem_addr      = r_pc;
  assign imem_req_valid = r_req_valid;
  assign inst           = r_inst;
  assign inst_valid     = r_inst_valid;
  assign misalign       = r_misalign;

endmodule

`default_nettype wire
